// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with flushable control field and non-flushed data field.
// Define PIPE_STAGE_SKID_EN to add the skid register so in_ready is a pure register output.
`timescale 1ns/1ps
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: an entry moves across a port on a rising edge where valid and ready
    // are both high; valid never depends on ready, and a held entry stays stable until taken.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              accept;
    logic              transfer;

    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = out_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    // in_ready_q tracks "next state is not SKID" so out_ready never reaches in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            m_ctrl     <= '0;
            m_data     <= '0;
            s_ctrl     <= '0;
            s_data     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            m_ctrl     <= '0;
            s_ctrl     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (accept && transfer) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (accept) begin
                        s_ctrl     <= in_ctrl;
                        s_data     <= in_data;
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (transfer) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (transfer) begin
                        m_ctrl     <= s_ctrl;
                        m_data     <= s_data;
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // Without a skid slot the stage can only refill in the cycle its entry leaves.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            m_ctrl <= '0;
        end else if (accept) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
            state  <= FULL;
        end else if (transfer) begin
            state <= EMPTY;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: queue model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int CW = 8;
    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks = 0;
    int failures = 0;

    logic [CW-1:0] q_ctrl[$];
    logic [DW-1:0] q_data[$];
    logic [DW-1:0] last_data = '0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capacity is two entries with the skid slot, otherwise one that can turn over each cycle.
    function automatic logic model_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q_ctrl.size() < 2;
`else
        return q_ctrl.size() == 0 || out_ready;
`endif
    endfunction

    task automatic model_clear();
        q_ctrl.delete();
        q_data.delete();
        last_data = '0;
    endtask

    task automatic model_step();
        logic acc;
        logic xfer;
        if (!reset) begin
            model_clear();
            return;
        end
        acc  = in_valid && model_in_ready();
        xfer = (q_ctrl.size() != 0) && out_ready;
        if (flush) begin
            q_ctrl.delete();
            q_data.delete();
        end else begin
            if (xfer) begin
                void'(q_ctrl.pop_front());
                void'(q_data.pop_front());
            end
            if (acc) begin
                q_ctrl.push_back(in_ctrl);
                q_data.push_back(in_data);
            end
        end
        if (q_data.size() != 0) last_data = q_data[0];
    endtask

    // Compare process: every negative edge the outputs must match the queue model.
    always @(negedge clk) begin
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        ev = (q_ctrl.size() != 0);
        ec = ev ? q_ctrl[0] : '0;
        ed = ev ? q_data[0] : last_data;
        chk("m_out_valid", DW'(out_valid), DW'(ev));
        chk("m_out_ctrl", DW'(out_ctrl), DW'(ec));
        chk("m_out_data", out_data, ed);
        chk("m_occupancy", DW'(occupancy), DW'(q_ctrl.size()));
        chk("m_in_ready", DW'(in_ready), DW'(model_in_ready()));
    end

    task automatic drive(input logic f, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vpat;
        logic [15:0] rpat;
        vpat = 16'b1011_0111_1100_1101;
        rpat = 16'b0110_1011_0011_1110;

        // Reset state
        cyc();
        cyc();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_ctrl", DW'(out_ctrl), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_occupancy", DW'(occupancy), '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        reset = 1'b1;

        // Streaming: one entry per cycle after one cycle of latency
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, CW'(i), DW'(32'h1000 + i), 1'b1);
            cyc();
            chk("stream_ctrl", DW'(out_ctrl), DW'(i));
            chk("stream_occ", DW'(occupancy), DW'(1));
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        chk("stream_drain_occ", DW'(occupancy), '0);
        chk("stream_drain_data", out_data, DW'(32'h100A));

        // Backpressure
        drive(1'b0, 1'b1, 8'h11, DW'(16'hAAAA), 1'b0);
        cyc();
        chk("bp_a_ctrl", DW'(out_ctrl), DW'(8'h11));
        drive(1'b0, 1'b1, 8'h22, DW'(16'hBBBB), 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        cyc();
        chk("bp_occ2", DW'(occupancy), DW'(2));
        chk("bp_in_ready0", DW'(in_ready), '0);
        chk("bp_head_a", DW'(out_ctrl), DW'(8'h11));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        chk("bp_b_ctrl", DW'(out_ctrl), DW'(8'h22));
        chk("bp_b_occ", DW'(occupancy), DW'(1));
        chk("bp_in_ready1", DW'(in_ready), DW'(1));
        cyc();
        chk("bp_empty", DW'(out_valid), '0);
`else
        #1;
        chk("ns_in_ready0", DW'(in_ready), '0);
        cyc();
        chk("ns_hold_ctrl", DW'(out_ctrl), DW'(8'h11));
        chk("ns_occ1", DW'(occupancy), DW'(1));
        drive(1'b0, 1'b1, 8'h22, DW'(16'hBBBB), 1'b1);
        #1;
        chk("ns_in_ready_comb", DW'(in_ready), DW'(1));
        cyc();
        chk("ns_replace_ctrl", DW'(out_ctrl), DW'(8'h22));
        chk("ns_replace_data", out_data, DW'(16'hBBBB));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        chk("ns_empty", DW'(out_valid), '0);
`endif

        // Flush while holding everything it can, with an entry arriving
        drive(1'b0, 1'b1, 8'h44, DW'(16'hC0DE), 1'b0);
        cyc();
        drive(1'b0, 1'b1, 8'h55, DW'(16'hF00D), 1'b0);
        cyc();
        drive(1'b1, 1'b1, 8'h33, DW'(16'h3333), 1'b0);
        cyc();
        chk("fl_out_valid", DW'(out_valid), '0);
        chk("fl_occ", DW'(occupancy), '0);
        chk("fl_out_ctrl", DW'(out_ctrl), '0);
        chk("fl_data_kept", out_data, DW'(16'hC0DE));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        chk("fl_arrival_lost", DW'(out_valid), '0);

        // Flush beats a simultaneous accept and transfer
        drive(1'b0, 1'b1, 8'h66, DW'(16'h6666), 1'b1);
        cyc();
        drive(1'b1, 1'b1, 8'h77, DW'(16'h7777), 1'b1);
        cyc();
        chk("fl2_occ", DW'(occupancy), '0);

        // Mixed valid/ready patterns exercise ordering through the model
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, vpat[i], CW'(8'h80 + i), DW'(32'hA000_0000 + i), rpat[i]);
            cyc();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("mix_drained", DW'(occupancy), '0);

        // Asynchronous reset mid-cycle while FULL
        drive(1'b0, 1'b1, 8'h05, DW'(16'hDEAD), 1'b0);
        cyc();
        chk("ar_pre_data", out_data, DW'(16'hDEAD));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("ar_out_valid", DW'(out_valid), '0);
        chk("ar_out_data", out_data, '0);
        chk("ar_occ", DW'(occupancy), '0);
        chk("ar_in_ready", DW'(in_ready), DW'(1));
        cyc();
        reset = 1'b1;

        // First accept at the first edge after release
        drive(1'b0, 1'b1, 8'h99, DW'(16'h9999), 1'b0);
        cyc();
        chk("post_rst_accept", DW'(out_ctrl), DW'(8'h99));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the control field, which flush clears.
REQ-002 SHALL have parameter DATA_W, default 160, width of the data field, which flush does not clear.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous kill of every held and arriving entry.
REQ-006 SHALL have port in_valid, input, 1, upstream entry present.
REQ-007 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, upstream control field.
REQ-009 SHALL have port in_data, input, DATA_W, upstream data field.
REQ-010 SHALL have port out_valid, output, 1, entry presented downstream.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-012 SHALL have port out_ctrl, output, CTRL_W, presented control field.
REQ-013 SHALL have port out_data, output, DATA_W, presented data field.
REQ-014 SHALL have port occupancy, output, 2, count of held entries, 0..2.

Function
REQ-015 SHALL accept an entry when in_valid and in_ready are both high at a rising edge.
REQ-016 SHALL transfer an entry downstream when out_valid and out_ready are both high.
REQ-017 SHALL hold a main register (M) and a skid register (S), with states EMPTY (none), FULL (M), and SKID (M and S).
REQ-018 SHALL, in EMPTY, go to FULL on accept and otherwise stay in EMPTY.
REQ-019 SHALL, in FULL, on accept with transfer, load M from input and stay in FULL.
REQ-020 SHALL, in FULL, on accept without transfer, load S from input and go to SKID.
REQ-021 SHALL, in FULL, on transfer without accept, go to EMPTY.
REQ-022 SHALL, in SKID, on transfer, move S to M and go to FULL.
REQ-023 SHALL, in SKID, on no transfer, hold M and S unchanged.
REQ-024 SHALL drive in_ready = (state != SKID) from a register only, with no combinational path from out_ready.
REQ-025 SHALL have latency of 1 cycle from accept to out_valid when EMPTY.
REQ-026 SHALL preserve order, so entries leave in the order they were accepted.
REQ-027 SHALL keep out_ctrl and out_data stable while out_valid is high and out_ready is low.
REQ-028 SHALL, on flush, go to EMPTY next cycle, zero the M and S control fields, and leave the data fields unchanged.
REQ-029 SHALL give flush priority over a simultaneous accept and a simultaneous transfer, discarding any arriving entry.
REQ-030 SHALL drive out_valid = (state != EMPTY), with occupancy encoded as EMPTY=0, FULL=1, SKID=2; occupancy never equals 3.
REQ-031 SHALL force out_ctrl to zero whenever out_valid is low.

Reset
REQ-032 SHALL, when reset is low, immediately and asynchronously go to EMPTY with M and S ctrl/data zero, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-033 SHALL, when reset asserts mid-transfer, discard all held entries, with no partial state retained.
REQ-034 SHALL remove reset synchronously to clk, with the first accept possible at the first edge after deassertion.

Configuration
REQ-035 SHALL, when macro PIPE_STAGE_SKID_EN is defined, implement REQ-017..REQ-024 as specified.
REQ-036 SHALL, when PIPE_STAGE_SKID_EN is undefined, omit the S register and the SKID state.
REQ-037 SHALL, when PIPE_STAGE_SKID_EN is undefined, drive in_ready = !out_valid || out_ready combinationally and cap occupancy at 1.
REQ-038 SHALL, with or without PIPE_STAGE_SKID_EN, apply flush, reset and ordering rules unchanged.

Verification
REQ-039 SHALL cover streaming: in_valid=1 and out_ready=1 held for 10 cycles, inputs ctrl=0x01..0x0A -> out_ctrl sequence 0x01..0x0A, one per cycle after 1-cycle latency, occupancy=1 throughout.
REQ-040 SHALL cover backpressure (SKID_EN): accept A=0x11 then B=0x22 with out_ready=0 -> occupancy=2 and in_ready=0; raise out_ready -> A out, then B out, in_ready=1 again.
REQ-041 SHALL cover flush in SKID: state SKID, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, M/S ctrl=0, arriving entry lost.
REQ-042 SHALL cover async reset: reset low mid-cycle while FULL with out_data=0xDEAD -> out_valid=0 and out_data=0 before the next clk edge.
REQ-043 SHALL cover no-skid build: without PIPE_STAGE_SKID_EN, FULL with out_ready=0 -> in_ready=0; out_ready=1 with in_valid=1 -> in_ready=1 in the same cycle and M replaced.
